// File: rtl/seq_detector.sv
// Serial pattern detector: compares the most recent cfg_len accepted bits
// against a run-time loaded pattern. Supports overlapping and non-overlapping
// matching and keeps a saturating match counter.
module seq_detector #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_load_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [LEN_W-1:0] pat_len_i,
    input  logic             overlap_i,
    input  logic             d_valid_i,
    input  logic             d_i,
    input  logic             cnt_clr_i,
    output logic             detected_o,
    output logic [CNT_W-1:0] match_count_o,
    output logic             armed_o
);

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StRun
    } state_e;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   cfg_pat_q, cfg_pat_d;
    logic [LEN_W-1:0]   cfg_len_q, cfg_len_d;
    logic               cfg_ovl_q, cfg_ovl_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               detected_q, detected_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [LEN_W-1:0]   len_clamp;
    logic [PAT_W-1:0]   mask;
    logic [PAT_W-1:0]   hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic               match;

    // Clamp requested length into 1..PAT_W before latching.
    always_comb begin
        len_clamp = pat_len_i;
        if (pat_len_i == '0) begin
            len_clamp = LEN_W'(1);
        end else if (pat_len_i > LEN_W'(PAT_W)) begin
            len_clamp = LEN_W'(PAT_W);
        end
    end

    // Compare mask: low cfg_len bits set.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < cfg_len_q);
        end
    end

    // Candidate history/fill after accepting d_i, and the match test on them.
    always_comb begin
        hist_n = {hist_q[PAT_W-2:0], d_i};
        fill_n = (fill_q < cfg_len_q) ? fill_q + LEN_W'(1) : fill_q;
        match  = (fill_n == cfg_len_q) && ((hist_n & mask) == (cfg_pat_q & mask));
    end

    // Next-state: config load, bit accept, match handling, counter clear.
    always_comb begin
        state_d    = state_q;
        cfg_pat_d  = cfg_pat_q;
        cfg_len_d  = cfg_len_q;
        cfg_ovl_d  = cfg_ovl_q;
        hist_d     = hist_q;
        fill_d     = fill_q;
        detected_d = 1'b0;
        cnt_d      = cnt_q;

        if (cfg_load_i) begin
            // A bit arriving with the load strobe is dropped.
            cfg_pat_d = pattern_i;
            cfg_len_d = len_clamp;
            cfg_ovl_d = overlap_i;
            hist_d    = '0;
            fill_d    = '0;
            state_d   = StFill;
        end else if (d_valid_i && (state_q != StIdle)) begin
            hist_d = hist_n;
            fill_d = fill_n;
            if (match) begin
                detected_d = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (!cfg_ovl_q) begin
                    // Old history stays; a zero fill blocks premature re-match.
                    fill_d  = '0;
                    state_d = StFill;
                end else begin
                    state_d = StRun;
                end
            end else if (fill_n == cfg_len_q) begin
                state_d = StRun;
            end
        end

        if (cnt_clr_i) begin
            cnt_d = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cfg_pat_q  <= '0;
            cfg_len_q  <= '0;
            cfg_ovl_q  <= 1'b0;
            hist_q     <= '0;
            fill_q     <= '0;
            detected_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cfg_pat_q  <= cfg_pat_d;
            cfg_len_q  <= cfg_len_d;
            cfg_ovl_q  <= cfg_ovl_d;
            hist_q     <= hist_d;
            fill_q     <= fill_d;
            detected_q <= detected_d;
            cnt_q      <= cnt_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        detected_o    = detected_q;
        match_count_o = cnt_q;
        armed_o       = (state_q != StIdle);
    end

endmodule

// File: tb/tb_seq_detector.sv
// Directed, table-driven bench for seq_detector (PAT_W=8, CNT_W=2).
module tb_seq_detector;

    localparam int unsigned PAT_W = 8;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned LEN_W = 4;

    logic             clk;
    logic             rst_n;
    logic             cfg_load;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] pat_len;
    logic             overlap;
    logic             d_valid;
    logic             d;
    logic             cnt_clr;
    logic             detected;
    logic [CNT_W-1:0] match_count;
    logic             armed;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             cfg;
        logic [PAT_W-1:0] pat;
        logic [LEN_W-1:0] len;
        logic             ovl;
        logic             dv;
        logic             d;
        logic             clr;
        logic             det;
        logic [CNT_W-1:0] cnt;
        logic             arm;
    } vec_t;

    vec_t tbl[$];

    seq_detector #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W),
        .LEN_W(LEN_W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cfg_load_i   (cfg_load),
        .pattern_i    (pattern),
        .pat_len_i    (pat_len),
        .overlap_i    (overlap),
        .d_valid_i    (d_valid),
        .d_i          (d),
        .cnt_clr_i    (cnt_clr),
        .detected_o   (detected),
        .match_count_o(match_count),
        .armed_o      (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic cf, input logic [PAT_W-1:0] pt,
                                input logic [LEN_W-1:0] ln, input logic ov,
                                input logic dv, input logic db, input logic cl,
                                input logic edet, input logic [CNT_W-1:0] ecnt,
                                input logic earm);
        vec_t v;
        v.cfg = cf;  v.pat = pt;   v.len = ln;   v.ovl = ov;
        v.dv  = dv;  v.d   = db;   v.clr = cl;
        v.det = edet; v.cnt = ecnt; v.arm = earm;
        return v;
    endfunction

    // Shorthand for a plain data bit.
    function automatic vec_t bitv(input logic db, input logic edet,
                                  input logic [CNT_W-1:0] ecnt);
        return mk(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, db, 1'b0, edet, ecnt, 1'b1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cfg_load = 1'b0; pattern = '0; pat_len = '0; overlap = 1'b0;
        d_valid = 1'b0; d = 1'b0; cnt_clr = 1'b0;
    endtask

    // Drive a bit (or nothing) for one cycle and sample just after the edge.
    task automatic step(input logic dv, input logic db);
        d_valid = dv; d = db;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            cfg_load = tbl[i].cfg; pattern = tbl[i].pat; pat_len = tbl[i].len;
            overlap = tbl[i].ovl; d_valid = tbl[i].dv; d = tbl[i].d;
            cnt_clr = tbl[i].clr;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_detected", i), int'(detected), int'(tbl[i].det));
            chk($sformatf("row%0d_count", i), int'(match_count), int'(tbl[i].cnt));
            chk($sformatf("row%0d_armed", i), int'(armed), int'(tbl[i].arm));
            idle_inputs();
        end
    endtask

    int seg_a, seg_b, seg_c, seg_d;

    initial begin
        idle_inputs();
        rst_n = 1'b0;

        // A: pattern 101, overlapping -> hits after bits 3 and 5.
        tbl.push_back(mk(1, 8'h05, 4'd3, 1, 0, 0, 0, 0, 2'd0, 1));
        tbl.push_back(bitv(1, 0, 2'd0));
        tbl.push_back(bitv(0, 0, 2'd0));
        tbl.push_back(bitv(1, 1, 2'd1));
        tbl.push_back(bitv(0, 0, 2'd1));
        tbl.push_back(bitv(1, 1, 2'd2));
        tbl.push_back(mk(0, 8'h00, 4'd0, 0, 0, 1, 0, 0, 2'd2, 1));
        tbl.push_back(mk(0, 8'h00, 4'd0, 0, 0, 0, 1, 0, 2'd0, 1));
        // B: same stream, non-overlapping -> only after bit 3.
        tbl.push_back(mk(1, 8'h05, 4'd3, 0, 0, 0, 0, 0, 2'd0, 1));
        tbl.push_back(bitv(1, 0, 2'd0));
        tbl.push_back(bitv(0, 0, 2'd0));
        tbl.push_back(bitv(1, 1, 2'd1));
        tbl.push_back(bitv(0, 0, 2'd1));
        tbl.push_back(bitv(1, 0, 2'd1));
        seg_a = tbl.size();
        // C: refill completes (010 no hit), then 101 hits again.
        tbl.push_back(bitv(0, 0, 2'd1));
        tbl.push_back(bitv(1, 1, 2'd2));
        tbl.push_back(mk(0, 8'h00, 4'd0, 0, 0, 0, 1, 0, 2'd0, 1));
        // Length 1, saturating 2-bit counter, then clear racing a match.
        tbl.push_back(mk(1, 8'h01, 4'd1, 1, 0, 0, 0, 0, 2'd0, 1));
        tbl.push_back(bitv(1, 1, 2'd1));
        tbl.push_back(bitv(1, 1, 2'd2));
        tbl.push_back(bitv(1, 1, 2'd3));
        tbl.push_back(bitv(1, 1, 2'd3));
        tbl.push_back(bitv(1, 1, 2'd3));
        tbl.push_back(mk(0, 8'h00, 4'd0, 0, 1, 1, 1, 1, 2'd0, 1));
        tbl.push_back(bitv(0, 0, 2'd0));
        // pat_len=0 acts as 1.
        tbl.push_back(mk(1, 8'h01, 4'd0, 1, 0, 0, 0, 0, 2'd0, 1));
        tbl.push_back(bitv(1, 1, 2'd1));
        tbl.push_back(bitv(0, 0, 2'd1));
        tbl.push_back(bitv(1, 1, 2'd2));
        // pat_len=9 clamps to 8: A5 = 1,0,1,0,0,1,0,1.
        tbl.push_back(mk(1, 8'hA5, 4'd9, 1, 0, 0, 0, 0, 2'd2, 1));
        tbl.push_back(bitv(1, 0, 2'd2));
        tbl.push_back(bitv(0, 0, 2'd2));
        tbl.push_back(bitv(1, 0, 2'd2));
        tbl.push_back(bitv(0, 0, 2'd2));
        tbl.push_back(bitv(0, 0, 2'd2));
        tbl.push_back(bitv(1, 0, 2'd2));
        tbl.push_back(bitv(0, 0, 2'd2));
        tbl.push_back(bitv(1, 1, 2'd3));
        tbl.push_back(bitv(1, 0, 2'd3));
        tbl.push_back(mk(0, 8'h00, 4'd0, 0, 0, 1, 0, 0, 2'd3, 1));
        tbl.push_back(mk(0, 8'h00, 4'd0, 0, 0, 0, 1, 0, 2'd0, 1));
        // D: load collides with a bit; that bit is dropped.
        tbl.push_back(mk(1, 8'h05, 4'd3, 1, 0, 0, 0, 0, 2'd0, 1));
        tbl.push_back(bitv(1, 0, 2'd0));
        tbl.push_back(bitv(0, 0, 2'd0));
        tbl.push_back(mk(1, 8'h05, 4'd3, 1, 1, 1, 0, 0, 2'd0, 1));
        seg_b = tbl.size();
        tbl.push_back(bitv(1, 0, 2'd0));
        tbl.push_back(bitv(0, 0, 2'd0));
        tbl.push_back(bitv(1, 1, 2'd1));
        seg_c = tbl.size();
        seg_d = seg_c;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_detected", int'(detected), 0);
        chk("reset_count", int'(match_count), 0);
        chk("reset_armed", int'(armed), 0);
        // IDLE ignores data.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0; pattern = 8'h01; pat_len = 4'd1;
        step(1'b1, 1'b1);
        chk("idle_ignores_bit", int'(detected), 0);
        chk("idle_not_armed", int'(armed), 0);

        run_rows(0, seg_a);
        // Non-overlap: after bit 5 the FSM is back in FILL with two bits held.
        chk("nonovl_fill", int'(dut.fill_q), 2);
        chk("nonovl_state_fill", int'(dut.state_q), 1);
        run_rows(seg_a, seg_b);
        chk("load_drop_fill", int'(dut.fill_q), 0);
        run_rows(seg_b, seg_c);

        // Mid-stream reset: count is 1 here, history 1,0 would complete on a 1.
        cfg_load = 1'b1; pattern = 8'h05; pat_len = 4'd3; overlap = 1'b1;
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chk("pre_reset_count", int'(match_count), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_count", int'(match_count), 0);
        chk("async_reset_armed", int'(armed), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1);
        chk("post_reset_detected", int'(detected), 0);
        chk("post_reset_count", int'(match_count), 0);
        chk("post_reset_armed", int'(armed), 0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("post_reset_no_match", int'(detected), 0);
        chk("post_reset_fill", int'(dut.fill_q), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised serial pattern detector and successor to the fixed 2-bit-state "101" detector FSM. It accepts one bit per qualified cycle and compares the most recent N bits against a pattern loaded at run time, where N is 1..PAT_W. Overlapping or non-overlapping matching is selectable, and a saturating match counter is maintained. It sits on a serial bit stream after any deserialiser/sampler and feeds event or interrupt logic.

## Interface
- PAT_W, 8: maximum pattern length in bits (>= 2).
- CNT_W, 16: match counter width (>= 1).
- LEN_W, $clog2(PAT_W+1): derived width of pat_len; do not override.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset; asserted when 0. Deassertion is synchronised externally.
- cfg_load  in  1  one-cycle strobe; latches pattern, pat_len and overlap.
- pattern  in  PAT_W  bit [pat_len-1] = first bit received, bit [0] = last bit received.
- pat_len  in  LEN_W  active pattern length. 0 is treated as 1; values > PAT_W are treated as PAT_W.
- overlap  in  1  1 = overlapping matches, 0 = history restarts after each match.
- d_valid  in  1  qualifies d this cycle.
- d  in  1  serial data bit.
- cnt_clr  in  1  synchronous clear of match_count.
- detected  out  1  registered one-cycle match pulse.
- match_count  out  CNT_W  saturating count of matches.
- armed  out  1  high once a configuration has been loaded (state != IDLE).

## Operation
- Registers:
  - latched pattern, length and mode (cfg_pat, cfg_len, cfg_ovl);
  - history shift register hist[PAT_W-1:0] (newest bit in LSB);
  - fill counter fill (0..cfg_len);
  - FSM state in {IDLE, FILL, RUN}.
- IDLE: entered at reset. d_valid is ignored and detected stays 0. cfg_load moves the FSM to FILL.
- cfg_load, in any state:
  - latch the clamped config, clear hist and fill, go to FILL;
  - a d_valid in the same cycle is discarded and no match is evaluated;
  - match_count is not affected.
- Bit accept (d_valid=1, cfg_load=0, state != IDLE):
  - hist_n = {hist[PAT_W-2:0], d};
  - fill_n = min(fill+1, cfg_len).
- Match condition: fill_n == cfg_len and (hist_n & mask) == (cfg_pat & mask), where mask has the low cfg_len bits set.
- On a match:
  - detected <= 1 on the same edge;
  - match_count increments, holding at 2^CNT_W-1;
  - if cfg_ovl=0, fill <= 0 and the FSM goes to FILL. hist may keep its contents; fill gates any further match.
- State transitions:
  - FILL -> RUN when fill_n == cfg_len and there is no non-overlap match;
  - RUN -> FILL only on a non-overlap match or on cfg_load.
- d_valid=0: hist, fill and state hold; detected <= 0.
- cnt_clr: match_count <= 0. If cnt_clr coincides with a match, clear wins (count = 0), but detected still pulses.

## Timing
- Reset (rst=0), immediately and asynchronously:
  - detected=0, match_count=0, armed=0;
  - hist=0, fill=0, cfg_*=0, state=IDLE.
- Reset mid-stream discards all history and configuration; a new cfg_load is required.
- Latency: detected is high for exactly the one cycle after the edge that sampled the final pattern bit. match_count updates on that same edge.
- Back-to-back matches:
  - overlap=1 with pat_len=1 can pulse detected on consecutive cycles;
  - overlap=0 needs at least cfg_len accepted bits between pulses.
- armed rises on the edge that samples cfg_load and stays high until reset.

## Test plan
- PAT_W=8, pattern=8'h05, pat_len=3, overlap=1, stream 1,0,1,0,1 (d_valid=1 every cycle) -> detected after bits 3 and 5; match_count=2.
- Same stream with overlap=0 -> detected only after bit 3; match_count=1; state FILL after bit 5 with fill=2.
- CNT_W=2, pattern=1, pat_len=1, overlap=1, five 1-bits -> five consecutive detected pulses; match_count saturates at 3. Then cnt_clr concurrent with a sixth match -> count 0, detected=1.
- Load cfg, send 1,0, assert rst=0 for 2 cycles, release, send 1 -> detected=0, match_count=0, armed=0; bits are ignored until cfg_load.
- pattern=8'h05, pat_len=3, send 1,0, then cfg_load and d=1 in the same cycle -> no detect, fill=0. The following 1,0,1 -> detected.
- pat_len=0 with pattern bit0=1 -> behaves as length 1: every accepted 1 pulses detected. pat_len=9 with PAT_W=8 -> matches on all 8 bits.
